// File: rtl/conv_window_reader.sv
// conv_window_reader: read-side sequencer for the image RAM.
// Walks every KxK window of the stored IMG_DIM x IMG_DIM image in row-major
// order, issues one RAM read per window pixel, assembles the window and hands
// it to the convolution MAC over a valid/ready handshake. done pulses once
// after the last window is accepted.
//
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   start      begin a frame (sampled only in IDLE)
//   rd_en      RAM read strobe
//   rd_addr    RAM read address, row*IMG_DIM+col
//   rd_data    RAM read data, valid one cycle after rd_en/rd_addr
//   win_valid  window output valid
//   win_ready  consumer accepts window
//   win_data   window pixels, pixel k=r*K+c at bits [k*PIX_W +: PIX_W]
//   win_pos    window index, row-major
//   busy       high in every state except IDLE
//   done       one-cycle pulse at frame end
module conv_window_reader #(
    parameter int unsigned PIX_W   = 4,
    parameter int unsigned IMG_DIM = 4,
    parameter int unsigned K       = 3,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [PIX_W-1:0]       rd_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [K*K*PIX_W-1:0]   win_data,
    output logic [1:0]             win_pos,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned NPIX   = K * K;
    localparam int unsigned LAST_K = NPIX - 1;
    localparam int unsigned NWIN   = IMG_DIM - K + 1;
    localparam int unsigned K_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned WIN_W  = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [K_W-1:0]                 k_q, k_d;
    logic [WIN_W-1:0]               wr_q, wr_d;
    logic [WIN_W-1:0]               wc_q, wc_d;
    logic                           rd_en_d;
    logic [ADDR_W-1:0]              rd_addr_d;
    logic                           win_valid_d;
    logic [1:0]                     win_pos_d;
    logic                           busy_d;
    logic                           done_d;
    logic                           last_win;
    logic [NPIX-1:0][PIX_W-1:0]     slot_q;

    // RAM address of pixel k inside window (wr, wc)
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [WIN_W-1:0] wr,
        input logic [WIN_W-1:0] wc,
        input logic [K_W-1:0]   k
    );
        int unsigned row;
        int unsigned col;
        row = 32'(wr) + 32'(k) / K;
        col = 32'(wc) + 32'(k) % K;
        return ADDR_W'(row * IMG_DIM + col);
    endfunction

    assign last_win = (wr_q == WIN_W'(NWIN - 1)) && (wc_q == WIN_W'(NWIN - 1));
    assign win_data = slot_q;

    // Next-state logic; registered outputs are derived from the next state
    // so they line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_d        = wr_q;
        wc_d        = wc_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr;
        win_valid_d = 1'b0;
        win_pos_d   = win_pos;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    k_d     = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                end
            end
            S_FETCH: begin
                if (k_q == K_W'(LAST_K)) begin
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_WAIT: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (win_ready) begin
                    if (last_win) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        k_d     = '0;
                        if (wc_q == WIN_W'(NWIN - 1)) begin
                            wc_d = '0;
                            wr_d = wr_q + WIN_W'(1);
                        end else begin
                            wc_d = wc_q + WIN_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_FETCH);
        if (rd_en_d) begin
            rd_addr_d = pix_addr(wr_d, wc_d, k_d);
        end
        // window index only moves when a new fetch begins
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            win_pos_d = 2'(32'(wr_d) * NWIN + 32'(wc_d));
        end
        win_valid_d = (state_d == S_PRESENT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            wr_q      <= '0;
            wc_q      <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            win_valid <= 1'b0;
            win_pos   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wr_q      <= wr_d;
            wc_q      <= wc_d;
            rd_en     <= rd_en_d;
            rd_addr   <= rd_addr_d;
            win_valid <= win_valid_d;
            win_pos   <= win_pos_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Pixel capture: read data lags the address by one cycle, so FETCH
    // cycle k stores pixel k-1 and WAIT stores the final pixel.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            slot_q <= '0;
        end else if ((state_q == S_FETCH) && (k_q != '0)) begin
            slot_q[k_q - K_W'(1)] <= rd_data;
        end else if (state_q == S_WAIT) begin
            slot_q[LAST_K] <= rd_data;
        end
    end

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader with a behavioural RAM and a window
// scoreboard checked on every accepted handshake.
module tb_conv_window_reader;

    localparam int unsigned PIX_W   = 4;
    localparam int unsigned IMG_DIM = 4;
    localparam int unsigned K       = 3;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned WD      = K * K * PIX_W;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              start = 1'b0;
    logic              win_ready = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              win_valid;
    logic [WD-1:0]     win_data;
    logic [1:0]        win_pos;
    logic              busy;
    logic              done;

    conv_window_reader #(
        .PIX_W  (PIX_W),
        .IMG_DIM(IMG_DIM),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data (win_data),
        .win_pos  (win_pos),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [PIX_W-1:0] mem [16];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct packed {
        logic [WD-1:0] data;
        logic [1:0]    pos;
    } win_t;

    win_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WD-1:0] model_win(input int pos);
        logic [WD-1:0] w;
        int wr;
        int wc;
        wr = pos / 2;
        wc = pos % 2;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*4 +: 4] = mem[(wr+r)*4 + wc + c];
        return w;
    endfunction

    task automatic push_win(input int p);
        win_t e;
        e.data = model_win(p);
        e.pos  = 2'(p);
        sb.push_back(e);
    endtask

    task automatic push_frame();
        for (int p = 0; p < 4; p++) push_win(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake scoreboard, stall-stability and done counting
    logic          pv = 1'b0;
    logic [WD-1:0] pdata;
    logic [1:0]    ppos;
    always @(negedge clk) begin
        if (!clr_n) begin
            pv = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (win_valid && pv) begin
                check("hold_data", 64'(win_data), 64'(pdata));
                check("hold_pos", 64'(win_pos), 64'(ppos));
            end
            if (win_valid && win_ready) begin
                total++;
                assert (sb.size() > 0) else begin
                    bad++;
                    $error("FAIL extra_window observed pos=%0d expected none", win_pos);
                end
                if (sb.size() > 0) begin
                    win_t e;
                    e = sb.pop_front();
                    check("win_data", 64'(win_data), 64'(e.data));
                    check("win_pos", 64'(win_pos), 64'(e.pos));
                end
            end
            pv    = win_valid && !win_ready;
            pdata = win_data;
            ppos  = win_pos;
        end
    end

    logic              rv  [64];
    logic              re  [64];
    logic              rdn [64];
    logic              rb  [64];
    logic [ADDR_W-1:0] ra  [64];

    initial begin
        int n;
        int fv;
        int dc;
        logic [WD-1:0] d;
        logic [1:0]    p;
        logic [ADDR_W-1:0] exp_a [9];
        exp_a = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};

        // ---- reset state
        for (int a = 0; a < 16; a++) mem[a] = 4'(a);
        tick();
        tick();
        check("rst_rd_en", 64'(rd_en), 0);
        check("rst_rd_addr", 64'(rd_addr), 0);
        check("rst_valid", 64'(win_valid), 0);
        check("rst_data", 64'(win_data), 0);
        check("rst_pos", 64'(win_pos), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        clr_n = 1'b1;
        tick();

        // ---- A: ramp image, ready held high, cycle-accurate trace
        dc = done_cnt;
        push_frame();
        win_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e < 64; e++) begin
            tick();
            rv[e] = win_valid; re[e] = rd_en; rdn[e] = done; rb[e] = busy; ra[e] = rd_addr;
            if (e == 10) check("a_pos0_literal", 64'(win_data), 64'(36'hA98654210));
        end
        fv = -1;
        for (int e = 63; e >= 1; e--) if (rv[e]) fv = e;
        check("a_first_valid_edge", 64'(fv), 10);
        for (int i = 0; i < 9; i++) begin
            check("a_pos1_rd_en", 64'(re[11+i]), 1);
            check("a_pos1_addr", 64'(ra[11+i]), 64'(exp_a[i]));
        end
        check("a_rd_en_after_fetch", 64'(re[20]), 0);
        check("a_addr_held", 64'(ra[20]), 11);
        check("a_done_43", 64'(rdn[43]), 0);
        check("a_done_44", 64'(rdn[44]), 1);
        check("a_done_45", 64'(rdn[45]), 0);
        check("a_busy_44", 64'(rb[44]), 1);
        check("a_busy_45", 64'(rb[45]), 0);
        check("a_done_count", 64'(done_cnt - dc), 1);
        check("a_sb_empty", 64'(sb.size()), 0);

        // ---- B: stall pos0 with ready low, then release
        dc = done_cnt;
        push_frame();
        win_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!win_valid && n < 40) begin tick(); n++; end
        check("b_valid_seen", 64'(win_valid), 1);
        d = win_data;
        p = win_pos;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_stall_valid", 64'(win_valid), 1);
            check("b_stall_data", 64'(win_data), 64'(d));
            check("b_stall_pos", 64'(win_pos), 64'(p));
        end
        win_ready = 1'b1;
        tick();
        check("b_next_rd_en", 64'(rd_en), 1);
        check("b_next_addr", 64'(rd_addr), 1);
        check("b_next_pos", 64'(win_pos), 1);
        check("b_next_valid", 64'(win_valid), 0);
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        check("b_done_seen", 64'(done), 1);
        tick();
        check("b_busy_low", 64'(busy), 0);
        check("b_done_count", 64'(done_cnt - dc), 1);
        check("b_sb_empty", 64'(sb.size()), 0);

        // ---- C: start re-pulsed mid-frame and in the DONE cycle
        dc = done_cnt;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e < 64; e++) begin
            if (e == 24 || e == 45) start = 1'b1;
            if (e == 25 || e == 46) start = 1'b0;
            tick();
            rv[e] = win_valid; re[e] = rd_en; rdn[e] = done; rb[e] = busy;
        end
        check("c_done_44", 64'(rdn[44]), 1);
        check("c_no_restart", 64'(re[46]), 0);
        check("c_idle_busy", 64'(rb[60]), 0);
        check("c_idle_valid", 64'(rv[60]), 0);
        check("c_done_count", 64'(done_cnt - dc), 1);
        check("c_sb_empty", 64'(sb.size()), 0);

        // ---- D: asynchronous reset during pos1 fetch
        dc = done_cnt;
        push_win(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 14; e++) tick();
        check("d_in_fetch", 64'(rd_en), 1);
        clr_n = 1'b0;
        #1;
        check("d_rst_rd_en", 64'(rd_en), 0);
        check("d_rst_addr", 64'(rd_addr), 0);
        check("d_rst_valid", 64'(win_valid), 0);
        check("d_rst_data", 64'(win_data), 0);
        check("d_rst_pos", 64'(win_pos), 0);
        check("d_rst_busy", 64'(busy), 0);
        check("d_rst_done", 64'(done), 0);
        tick();
        tick();
        tick();
        clr_n = 1'b1;
        tick();
        tick();
        check("d_no_done", 64'(done_cnt - dc), 0);
        check("d_stays_idle", 64'(busy), 0);
        check("d_sb_empty", 64'(sb.size()), 0);
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        check("d_done_seen", 64'(done), 1);
        tick();
        check("d_done_count", 64'(done_cnt - dc), 1);
        check("d_sb_empty2", 64'(sb.size()), 0);

        // ---- E: all-ones image
        dc = done_cnt;
        for (int a = 0; a < 16; a++) mem[a] = 4'hF;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!win_valid && n < 40) begin tick(); n++; end
        check("e_data_literal", 64'(win_data), 64'(36'hF_FFFF_FFFF));
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        check("e_done_seen", 64'(done), 1);
        tick();
        check("e_done_count", 64'(done_cnt - dc), 1);
        check("e_sb_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Read-side sequencer for the 16-entry, 4-bit image RAM. It is the reader counterpart to the image loader that fills the RAM.
- Walks every 3x3 window of the stored 4x4 image in row-major order, issuing one RAM read per pixel.
- Assembles each 9-pixel window and hands it to the convolution MAC over a valid/ready handshake.
- Pulses done after the last window is accepted.

Parameters:
- PIX_W, 4, pixel width in bits
- IMG_DIM, 4, image width and height in pixels
- K, 3, kernel/window edge length
- ADDR_W, 4, RAM address width; must satisfy 2^ADDR_W >= IMG_DIM*IMG_DIM

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address, row-major: row*IMG_DIM+col
- rd_data  in  PIX_W  RAM read data, valid exactly 1 cycle after rd_en/rd_addr
- win_valid  out  1  window output valid
- win_ready  in  1  consumer accepts window
- win_data  out  K*K*PIX_W  window pixels; pixel k=r*K+c occupies bits [k*PIX_W+PIX_W-1 : k*PIX_W]
- win_pos  out  2  window index, 0..(IMG_DIM-K+1)^2-1, row-major
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE. rd_en, rd_addr, win_valid, win_data, win_pos, busy and done are all 0. Window counters and pixel counter are cleared.
- Reset asserted mid-frame aborts immediately. No done pulse. The next frame requires a new start.
- States:
  - IDLE: start=1 at a clock edge -> FETCH, with window (wr,wc)=(0,0) and k=0.
  - FETCH: rd_en=1, rd_addr=(wr+k/K)*IMG_DIM + wc + k%K. k increments every cycle. After k=K*K-1 -> WAIT.
  - WAIT: rd_en=0. Captures the last pixel. -> PRESENT.
  - PRESENT: win_valid=1.
    - On win_valid&&win_ready at an edge: if this was the last window -> DONE; else advance the window (wc increments, wraps to 0 at IMG_DIM-K+1 with wr incrementing), k=0, -> FETCH.
    - Without ready: remain in PRESENT, with win_data and win_pos held stable.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Capture: rd_data is registered into slot k-1 during each FETCH cycle with k>=1, and into slot K*K-1 during WAIT. Slots are written only by these captures.
- win_data holds the last window after the frame ends and until reset.
- win_pos changes only on entry to FETCH.
- Latency, measured from the edge that samples start:
  - win_valid rises after 11 edges.
  - Each subsequent window takes 11 cycles from the previous handshake (9 FETCH + 1 WAIT + 1 PRESENT).
  - With win_ready held at 1, the 4th handshake occurs at edge 44 and done is high in the cycle after edge 44.
- start while busy: ignored, including start asserted during the DONE cycle.
- win_ready while win_valid=0: ignored.
- rd_en is 0 in every state except FETCH. rd_addr is held at its last value when rd_en=0.
- No arithmetic overflow: the address is at most IMG_DIM*IMG_DIM-1 = 15.

Test Plan:
- RAM preloaded with pixel[a]=a, start pulse, win_ready=1 -> windows in order:
  - pos0 = {0,1,2,4,5,6,8,9,10}
  - pos1 = {1,2,3,5,6,7,9,10,11}
  - pos2 = {4,5,6,8,9,10,12,13,14}
  - pos3 = {5,6,7,9,10,11,13,14,15}
  - done pulses once, one cycle after the 4th handshake; busy falls at the same time.
- Address trace for pos1 -> rd_addr sequence 1,2,3,5,6,7,9,10,11 on 9 consecutive cycles with rd_en=1, then rd_en=0.
- win_ready held 0 for 5 cycles in pos0 -> win_valid stays 1, win_data and win_pos unchanged. The handshake on the first cycle ready=1 starts pos1 fetch on the next cycle.
- start pulsed again at pos2 and during the DONE cycle -> no effect; exactly 4 windows and 1 done.
- clr_n driven low during pos1 FETCH -> all outputs 0 asynchronously, no done. A new start after release yields pos0 = {0,1,2,4,5,6,8,9,10}.
- RAM preloaded with all 4'hF -> every window's win_data = 36'hF_FFFF_FFFF, win_pos 0..3 in order.
